// File: rtl/tile_pkg.sv
// Shared board geometry, LFSR taps, sequencer state encoding and the initial tile layout.
package tile_pkg;

  localparam int NUM_TILES = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  localparam logic [DATA_W-1:0] TILE_EMPTY = '0;
  localparam logic [15:0]       LFSR_TAPS  = 16'hB400;

  typedef enum logic [3:0] {
    IDLE, FILL, PICK, RD_I, RD_J, CAP, WR_I, WR_J, DONE
  } seq_state_t;

  // Ordered layout before shuffling: address k holds pair id (k/2)+1, never TILE_EMPTY.
  function automatic logic [DATA_W-1:0] fill_value(input logic [ADDR_W-1:0] k);
    return DATA_W'({1'b0, k[ADDR_W-1:1]}) + DATA_W'(1);
  endfunction

endpackage

// File: rtl/board_init_sequencer_lfsr16.sv
// 16-bit Galois LFSR, free running; a load replaces the state, with zero mapped to the default seed.
module lfsr16
  import tile_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] out
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= SEED;
    end else if (load) begin
      // All-zero is the lock-up state of the LFSR, so it is never loaded.
      out <= (seed == 16'h0000) ? SEED : seed;
    end else begin
      out <= out[0] ? ((out >> 1) ^ LFSR_TAPS) : (out >> 1);
    end
  end

endmodule

// File: rtl/board_init_sequencer.sv
// Fills the board RAM with ordered tile pairs, shuffles it in place (Fisher-Yates),
// then returns RAM port A to the in-game FSM.
module board_init_sequencer
  import tile_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          REJECT_MAX = 15
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  output logic              busy,
  output logic              done,
  output logic              game_grant,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic [DATA_W-1:0] game_wdata,
  input  logic              game_we,
  output logic [DATA_W-1:0] game_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(NUM_TILES - 1);
  localparam logic [7:0]        REJ_LIM = 8'(REJECT_MAX);

  logic [15:0]       lfsr;
  seq_state_t        state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [7:0]        rejects;
  logic [DATA_W-1:0] ti;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_wdata;
  logic              seq_we;
  logic [ADDR_W-1:0] draw;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLOCK_50),
    .reset (reset),
    .load  (seed_load),
    .seed  (seed),
    .out   (lfsr)
  );

  assign draw = lfsr[ADDR_W-1:0];

  // Port A mux: the game side is dropped, not queued, while the sequencer owns the RAM.
  assign ram_addr   = busy ? seq_addr  : game_addr;
  assign ram_wdata  = busy ? seq_wdata : game_wdata;
  assign ram_we     = busy ? seq_we    : game_we;
  assign game_grant = ~busy;
  assign game_rdata = ram_rdata;

  // Port A drive is registered: each transition loads what the next state presents.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      seq_we    <= 1'b0;
      seq_addr  <= '0;
      seq_wdata <= TILE_EMPTY;
      k         <= '0;
      i         <= '0;
      j         <= '0;
      rejects   <= '0;
      ti        <= TILE_EMPTY;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= FILL;
          busy      <= 1'b1;
          k         <= '0;
          seq_we    <= 1'b1;
          seq_addr  <= '0;
          seq_wdata <= fill_value('0);
        end
        FILL: if (k == LAST) begin
          state  <= PICK;
          i      <= LAST;
          seq_we <= 1'b0;
        end else begin
          k         <= k + 1'b1;
          seq_addr  <= k + 1'b1;
          seq_wdata <= fill_value(k + 1'b1);
        end
        PICK: begin
          // The reject cap bounds swap latency; a self-swap is always a legal draw.
          if (rejects == REJ_LIM) begin
            j        <= i;
            rejects  <= '0;
            state    <= RD_I;
            seq_addr <= i;
          end else if (draw <= i) begin
            j        <= draw;
            rejects  <= '0;
            state    <= RD_I;
            seq_addr <= i;
          end else begin
            rejects <= rejects + 8'd1;
          end
        end
        RD_I: begin
          state    <= RD_J;
          seq_addr <= j;
        end
        RD_J: begin
          ti    <= ram_rdata;
          state <= CAP;
        end
        CAP: begin
          state     <= WR_I;
          seq_we    <= 1'b1;
          seq_addr  <= i;
          seq_wdata <= ram_rdata;
        end
        WR_I: begin
          state     <= WR_J;
          seq_addr  <= j;
          seq_wdata <= ti;
        end
        WR_J: begin
          seq_we <= 1'b0;
          if (i == ADDR_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            i     <= i - 1'b1;
            state <= PICK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_init_sequencer.sv
// Directed bench: two sequencers (default and REJECT_MAX=0) each with a behavioural board RAM.
module tb_board_init_sequencer;
  import tile_pkg::*;

  typedef logic [DATA_W-1:0] img_t [NUM_TILES];

  logic              CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic              reset = 1'b1, start = 1'b0, seed_load = 1'b0, game_we = 1'b0;
  logic [15:0]       seed = '0;
  logic [ADDR_W-1:0] game_addr = '0, ram_addr;
  logic [DATA_W-1:0] game_wdata = '0, ram_wdata, ram_rdata, game_rdata;
  logic              busy, done, game_grant, ram_we;

  logic              reset_b = 1'b1, start_b = 1'b0, game_we_b = 1'b0;
  logic [ADDR_W-1:0] game_addr_b = '0, ram_addr_b;
  logic [DATA_W-1:0] game_wdata_b = '0, ram_wdata_b, ram_rdata_b, game_rdata_b;
  logic              busy_b, done_b, game_grant_b, ram_we_b;

  img_t mem_a, mem_b;

  board_init_sequencer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .seed_load(seed_load), .seed(seed),
    .busy(busy), .done(done), .game_grant(game_grant), .game_addr(game_addr),
    .game_wdata(game_wdata), .game_we(game_we), .game_rdata(game_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  board_init_sequencer #(.REJECT_MAX(0)) dut_b (
    .CLOCK_50(CLOCK_50), .reset(reset_b), .start(start_b), .seed_load(seed_load), .seed(seed),
    .busy(busy_b), .done(done_b), .game_grant(game_grant_b), .game_addr(game_addr_b),
    .game_wdata(game_wdata_b), .game_we(game_we_b), .game_rdata(game_rdata_b),
    .ram_addr(ram_addr_b), .ram_wdata(ram_wdata_b), .ram_we(ram_we_b), .ram_rdata(ram_rdata_b)
  );

  // Synchronous RAMs: read data valid one cycle after the address, read-before-write.
  always @(posedge CLOCK_50) begin
    if (ram_we) mem_a[ram_addr] <= ram_wdata;
    ram_rdata <= mem_a[ram_addr];
    if (ram_we_b) mem_b[ram_addr_b] <= ram_wdata_b;
    ram_rdata_b <= mem_b[ram_addr_b];
  end

  int done_cnt = 0, busy_wr_cnt = 0, leak_cnt = 0;
  logic [ADDR_W-1:0] log_addr [16];
  logic [DATA_W-1:0] log_data [16];

  always @(negedge CLOCK_50) begin
    if (done) done_cnt <= done_cnt + 1;
    if (busy && ram_we) begin
      busy_wr_cnt <= busy_wr_cnt + 1;
      if (ram_wdata == 8'hEE) leak_cnt <= leak_cnt + 1;
      if (busy_wr_cnt < 16) begin
        log_addr[busy_wr_cnt] <= ram_addr;
        log_data[busy_wr_cnt] <= ram_wdata;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_b = 1'b0;
  endtask

  // cyc counts clock edges from the edge that sampled start to the one raising done.
  task automatic wait_done(input bit sel, output int cyc);
    cyc = 1;
    while (!(sel ? done_b : done) && cyc < 4000) begin
      tick();
      cyc++;
    end
    if (sel) check("done_seen_b", 32'(done_b), 1);
    else     check("done_seen", 32'(done), 1);
  endtask

  function automatic bit is_pairs(input img_t m);
    int c [NUM_TILES/2 + 1];
    foreach (c[v]) c[v] = 0;
    for (int a = 0; a < NUM_TILES; a++) begin
      if (m[a] >= 1 && m[a] <= NUM_TILES/2) c[m[a]]++;
      else return 1'b0;
    end
    for (int v = 1; v <= NUM_TILES/2; v++) if (c[v] != 2) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int cyc, cyc1, cyc2, d0, wr0, n;
    bit same;
    img_t img, img1, img2;

    repeat (3) tick();
    reset = 1'b0;
    reset_b = 1'b0;
    tick();

    // Reset state and idle pass-through.
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_grant", 32'(game_grant), 1);
    check("rst_ram_we", 32'(ram_we), 0);
    game_we = 1'b1; game_addr = 4'd3; game_wdata = 8'd5;
    #1;
    check("idle_we", 32'(ram_we), 1);
    check("idle_addr", 32'(ram_addr), 3);
    check("idle_wdata", 32'(ram_wdata), 5);
    game_we = 1'b0;

    // Full build with a game master hammering writes the whole time.
    tick();
    seed = 16'h0001; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    game_we = 1'b1; game_addr = 4'd7; game_wdata = 8'hEE;
    d0 = done_cnt; wr0 = busy_wr_cnt;
    pulse_start(0);
    check("busy_after_start", 32'(busy), 1);
    check("grant_after_start", 32'(game_grant), 0);
    wait_done(0, cyc);
    img = mem_a;
    check("min_latency", 32'(cyc >= 107), 1);
    check("done_busy", 32'(busy), 0);
    check("done_cycle_passthru", {ram_we, 4'(ram_addr)}, {1'b1, 4'd7});
    tick();
    check("single_pulse", 32'(done), 0);
    check("after_done_passthru", {ram_we, 4'(ram_addr), ram_wdata}, {1'b1, 4'd7, 8'hEE});
    game_we = 1'b0;
    check("done_count", 32'(done_cnt - d0), 1);
    check("seq_writes", 32'(busy_wr_cnt - wr0), 46);
    check("game_leak", 32'(leak_cnt), 0);
    for (int e = 0; e < 16; e++)
      check($sformatf("fill_%0d", e), {4'(log_addr[e]), log_data[e]}, {4'(e), 8'(e/2 + 1)});
    check("perm_run1", 32'(is_pairs(img)), 1);

    // Start while busy is ignored; reset beats a coincident start.
    d0 = done_cnt;
    pulse_start(0);
    repeat (40) tick();
    pulse_start(0);
    wait_done(0, cyc);
    repeat (150) tick();
    check("midstart_done_count", 32'(done_cnt - d0), 1);
    check("midstart_idle", 32'(busy), 0);
    start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    check("rst_start_busy", 32'(busy), 0);
    tick();
    check("rst_start_busy2", 32'(busy), 0);

    // Reset landing on the first WR_I.
    pulse_start(0);
    n = 0;
    while (ram_we && n < 500) begin tick(); n++; end
    while (!ram_we && n < 500) begin tick(); n++; end
    check("reach_wr_i", 32'(n < 500), 1);
    check("wr_i_addr", 32'(ram_addr), 15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_we", 32'(ram_we), 0);
    check("midrst_grant", 32'(game_grant), 1);
    pulse_start(0);
    wait_done(0, cyc);
    img = mem_a;
    check("perm_after_rst", 32'(is_pairs(img)), 1);

    // Zero seed maps to the default; identical timing gives identical boards.
    tick();
    seed = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("lfsr_default1", 32'(dut.lfsr), 32'h0000ACE1);
    pulse_start(0);
    wait_done(0, cyc1);
    img1 = mem_a;
    repeat (5) tick();
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("lfsr_default2", 32'(dut.lfsr), 32'h0000ACE1);
    pulse_start(0);
    wait_done(0, cyc2);
    img2 = mem_a;
    check("repeat_cycles", 32'(cyc2), 32'(cyc1));
    same = 1'b1;
    for (int a = 0; a < NUM_TILES; a++) if (img1[a] !== img2[a]) same = 1'b0;
    check("repeat_image", 32'(same), 1);
    check("perm_seeded", 32'(is_pairs(img1)), 1);

    // REJECT_MAX=0: every draw is a self-swap, minimum latency, board stays ordered.
    pulse_start(1);
    wait_done(1, cyc);
    img = mem_b;
    check("nomix_latency", 32'(cyc), 107);
    for (int a = 0; a < NUM_TILES; a++)
      check($sformatf("nomix_%0d", a), 32'(img[a]), 32'(a/2 + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
